regfile_writer: RTL
===================

# regfile_writer

Write-port sequencer for the 32×32 register file. It merges two result sources onto the single `we`/`wa`/`wd` write port. The first is the in-order pipeline writeback (`p_*`), which has absolute priority and no backpressure. The second is the multi-cycle unit (mult/div, `m_*`), which uses a valid/ready handshake and is buffered in a small FIFO. It also keeps a per-register scoreboard of outstanding multi-cycle destinations so hazard logic can stall readers.

## Interface
Parameters:
- `DEPTH`, default 2: multi-cycle FIFO entries; legal range 2..8.
- `CW`, default 2: count width, equal to clog2(DEPTH+1), rounded up.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `p_valid` in 1: pipeline writeback result present this cycle.
- `p_wa` in 5: pipeline destination register.
- `p_wd` in 32: pipeline result data.
- `m_valid` in 1: multi-cycle result offered.
- `m_ready` out 1: FIFO can accept; equals `count < DEPTH` and `!rst`.
- `m_wa` in 5: multi-cycle destination register.
- `m_wd` in 32: multi-cycle result data.
- `issue_valid` in 1: a multi-cycle op is being issued.
- `issue_wa` in 5: destination of the issued op.
- `we` out 1: register-file write enable (registered).
- `wa` out 5: register-file write address (registered).
- `wd` out 32: register-file write data (registered).
- `busy` out 32: scoreboard; bit n set means register n awaits a multi-cycle result.
- `fifo_count` out CW: current FIFO occupancy.
- `sb_err` out 1: sticky flag set on an issue to an already-busy register.

## Operation
- **Push.** On an edge with `m_valid && m_ready`, {`m_wa`, `m_wd`} is written at the FIFO tail.
- **Output select**, evaluated at every edge:
  - If `p_valid`: `wa`←`p_wa`, `wd`←`p_wd`, `we`←(`p_wa`≠0). The FIFO does not pop.
  - Else if `count` > 0: `wa`/`wd` ← FIFO head, `we`←(head `wa`≠0), and the FIFO pops.
  - Else: `we`←0; `wa`/`wd` hold their previous values.
- **Register 0.** Writes to register 0 are consumed (pop or accept) but never assert `we`.
- **Count update.** `count` = `count` + push − pop. Push and pop may occur on the same edge when `count` < `DEPTH`. At full, `m_ready`=0, so no push occurs even if a pop occurs that edge. Pointers wrap modulo `DEPTH`.
- **No bypass.** A multi-cycle result always passes through the FIFO.
- **Scoreboard set.** On `issue_valid && issue_wa`≠0, `busy[issue_wa]` is set.
- **Scoreboard clear.** When a FIFO entry is popped to the output, `busy[head wa]` is cleared. Pipeline writes never touch `busy`.
- **Same-edge set and clear** to one address: set wins, because the new op is outstanding.
- **Bit 0.** `busy[0]` is constant 0.
- **`sb_err`.** Set when `issue_valid` targets a register whose `busy` bit is already 1 and is not being cleared that edge. It stays set until `rst`. The issue is still recorded.
- **Reset values.** `rst` asserted, even mid-operation, asynchronously sets:
  - `we`=0, `wa`=0, `wd`=0;
  - `busy`=0, `count`=0, pointers=0;
  - `sb_err`=0, `m_ready`=0.
- **Entries lost on reset.** FIFO entries pending at reset are discarded.

## Timing
- **Pipeline path.** `p_*` sampled at edge N appears on `we`/`wa`/`wd` during cycle N→N+1. The register file captures it at edge N+1.
- **Multi-cycle path.** Handshake at edge N, then output at the earliest edge N+1 if `p_valid`=0 then. The register file captures it at edge N+2.
- **Stall behaviour.** Each cycle with `p_valid`=1 delays the FIFO head by one cycle. A continuous `p_valid` stalls the FIFO indefinitely; upstream pipeline bubbles guarantee drain.
- **`m_ready`** is a function of registered `count` only, with no combinational path from any input except `rst`.
- **`busy`** is registered. A bit clears in the same cycle its write appears on `we`. A reader sampling `busy`=0 at edge N+1 sees the data in the register file after edge N+1.
- **`fifo_count`** is registered and reflects the post-edge occupancy.

## Test plan
- **Reset.** Assert `rst` mid-cycle with 2 FIFO entries pending -> immediately `we`=0, `busy`=0, `fifo_count`=0, `m_ready`=0. After release: `m_ready`=1 and no spurious write.
- **Pipeline only.** `p_valid`=1, `p_wa`=5, `p_wd`=0xDEADBEEF for one cycle -> next cycle `we`=1, `wa`=5, `wd`=0xDEADBEEF. Then `p_wa`=0 -> `we`=0.
- **Multi-cycle with stall.**
  - Stimulus: issue `wa`=9 (expect `busy[9]`=1), then `m_valid` with `m_wd`=0x1234 while `p_valid`=1 for 3 cycles.
  - Required: `fifo_count`=1 and no m write during those 3 cycles.
  - Required: the first idle cycle gives `we`=1, `wa`=9, `wd`=0x1234, and `busy[9]` clears that same cycle.
- **FIFO full/backpressure** (`DEPTH`=2).
  - Stimulus: hold `p_valid`=1, push 2 m results.
  - Required: `m_ready`=0 and a third `m_valid` is held off.
  - Stimulus: drop `p_valid`, keep `m_valid`.
  - Required: entries drain in order, 1 per cycle; the third result is accepted when `count` drops to 1; no loss or reordering.
- **Scoreboard races.**
  - Issue to register 7 on the same edge its pending entry pops -> `busy[7]`=1 afterward, `sb_err`=0.
  - Issue to a busy register 7 -> `sb_err`=1, and it stays set after subsequent pops.
- **Register 0.** Issue and m result with `wa`=0 -> `busy[0]` never set, entry consumed, `we` stays 0, `fifo_count` returns to 0.

Source files
------------

// File: rtl/regfile_writer.sv
// ==========================================================================
// regfile_writer : merges pipeline and multi-cycle results onto one RF write
//                  port, with a FIFO for multi-cycle results and a busy board
// Revision 1.0
// ==========================================================================
`default_nettype none

module regfile_writer #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_valid,
  input  logic [4:0]    p_wa,
  input  logic [31:0]   p_wd,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [4:0]    m_wa,
  input  logic [31:0]   m_wd,
  input  logic          issue_valid,
  input  logic [4:0]    issue_wa,
  output logic          we,
  output logic [4:0]    wa,
  output logic [31:0]   wd,
  output logic [31:0]   busy,
  output logic [CW-1:0] fifo_count,
  output logic          sb_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   busy_q, busy_d;
  logic          sb_err_q, sb_err_d;

  logic [4:0]    mem_wa [DEPTH];
  logic [31:0]   mem_wd [DEPTH];

  logic          push;
  logic          pop;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_ready = !rst && (count_q < CW'(DEPTH));
  assign head_wa = mem_wa[rd_ptr_q];
  assign head_wd = mem_wd[rd_ptr_q];

  always_comb begin
    push     = m_valid && m_ready;
    pop      = !p_valid && (count_q != '0);
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    // Pipeline writeback always wins the port; the FIFO head waits.
    if (p_valid) begin
      we_d = (p_wa != 5'd0);
      wa_d = p_wa;
      wd_d = p_wd;
    end else if (pop) begin
      we_d     = (head_wa != 5'd0);
      wa_d     = head_wa;
      wd_d     = head_wd;
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    sb_err_d = sb_err_q
             | (issue_valid && busy_q[issue_wa] && !(pop && (head_wa == issue_wa)));

    // Clear before set so a same-edge reissue keeps the register busy.
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_wa] = 1'b0;
    end
    if (issue_valid && (issue_wa != 5'd0)) begin
      busy_d[issue_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Storage needs no reset: stale entries are never read once count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr_q] <= m_wa;
      mem_wd[wr_ptr_q] <= m_wd;
    end
  end

  assign we         = we_q;
  assign wa         = wa_q;
  assign wd         = wd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign sb_err     = sb_err_q;

endmodule

`default_nettype wire
